// File: rtl/pulse_param_loader.sv
// Parses HEADER-framed 20-byte parameter frames (8-bit payload sum checksum) and loads all outputs at once, one edge after the checksum byte.
// No backpressure: every rx_valid byte is consumed. Optional PARAM_SYNC_COMMIT_EN defers the load to the edge after cycle_start.
module pulse_param_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter logic [7:0]  HEADER         = 8'hA5
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        cycle_start,
  output logic [7:0]  per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [31:0] nut_w,
  output logic [31:0] nut_d,
  output logic        nut,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        pu,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        committed,
  output logic        busy
);

  typedef struct packed {
    logic [7:0]  per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [31:0] nut_w;
    logic [31:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
    logic        nut;
    logic        pu;
  } params_t;

  localparam params_t RESET_PARAMS = '{
    per: 8'd1, p1wid: 16'd30, del: 16'd200, p2wid: 16'd30,
    nut_w: 32'd50, nut_d: 32'd300, cp: 8'd3, p_bl: 8'd50,
    p_bl_off: 16'd100, bl: 1'b1, nut: 1'b1, pu: 1'b1
  };

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

  state_t         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [7:0]     sum_q, sum_d;
  logic [159:0]   stage_q, stage_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  params_t        out_q, out_d;
  logic           frame_ok_q, frame_ok_d;
  logic           frame_err_q, frame_err_d;
  logic           committed_q, committed_d;
  logic           accept;
  logic           timeout_hit;
  params_t        new_params;

`ifdef PARAM_SYNC_COMMIT_EN
  params_t        shadow_q, shadow_d;
  logic           pending_q, pending_d;
`else
  logic           unused_cycle_start;
  assign unused_cycle_start = cycle_start;
`endif

  // Staging buffer is a shift register, so byte 0 ends up in the MSBs; flag bits 7:3 are dropped.
  assign new_params = params_t'({stage_q[159:8], stage_q[2:0]});

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    stage_d     = stage_q;
    tmo_d       = tmo_q;
    out_d       = out_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    committed_d = 1'b0;
    accept      = 1'b0;
`ifdef PARAM_SYNC_COMMIT_EN
    shadow_d    = shadow_q;
    pending_d   = pending_q;
`endif

    if (state_q == IDLE || rx_valid) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end
    timeout_hit = (state_q != IDLE) && !rx_valid && (tmo_q == TMO_LAST);

    case (state_q)
      IDLE: begin
        if (rx_valid && rx_byte == HEADER) begin
          idx_d   = '0;
          sum_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (rx_valid) begin
          stage_d = {stage_q[151:0], rx_byte};
          sum_d   = sum_q + rx_byte;
          if (idx_q == 5'd19) begin
            state_d = CHECK;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      CHECK: begin
        if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (rx_valid) begin
          if (rx_byte == sum_q) begin
            accept     = 1'b1;
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PARAM_SYNC_COMMIT_EN
    // The older pending frame commits first; a frame accepted in the same cycle takes its place.
    if (cycle_start && pending_q) begin
      out_d       = shadow_q;
      committed_d = 1'b1;
      pending_d   = 1'b0;
    end
    if (accept) begin
      shadow_d  = new_params;
      pending_d = 1'b1;
    end
`else
    if (accept) begin
      out_d       = new_params;
      committed_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      stage_q     <= '0;
      tmo_q       <= '0;
      out_q       <= RESET_PARAMS;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      committed_q <= 1'b0;
`ifdef PARAM_SYNC_COMMIT_EN
      shadow_q    <= RESET_PARAMS;
      pending_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      stage_q     <= stage_d;
      tmo_q       <= tmo_d;
      out_q       <= out_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      committed_q <= committed_d;
`ifdef PARAM_SYNC_COMMIT_EN
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
`endif
    end
  end

  assign per       = out_q.per;
  assign p1wid     = out_q.p1wid;
  assign del       = out_q.del;
  assign p2wid     = out_q.p2wid;
  assign nut_w     = out_q.nut_w;
  assign nut_d     = out_q.nut_d;
  assign cp        = out_q.cp;
  assign p_bl      = out_q.p_bl;
  assign p_bl_off  = out_q.p_bl_off;
  assign bl        = out_q.bl;
  assign nut       = out_q.nut;
  assign pu        = out_q.pu;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign committed = committed_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_param_loader.sv
// Bench for pulse_param_loader: frame table, hand sequences for timeout/reset/deferred commit, then random frames against a field-level model.
module tb_pulse_param_loader;

  localparam int unsigned TMO = 100;
  localparam logic [7:0]  HDR = 8'hA5;

  typedef struct packed {
    logic [7:0]  per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [31:0] nut_w;
    logic [31:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic [7:0]  flags;
  } fields_t;

  typedef struct {
    fields_t    f;
    logic [7:0] delta;
    bit         exp_ok;
    logic [7:0] exp_per;
    logic [2:0] exp_bnp;
  } vec_t;

  localparam logic [154:0] RESET_VEC = {8'd1, 16'd30, 16'd200, 16'd30, 32'd50, 32'd300,
                                        8'd3, 8'd50, 16'd100, 1'b1, 1'b1, 1'b1};

  logic        clk_pll = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        cycle_start;
  logic [7:0]  per, cp, p_bl;
  logic [15:0] p1wid, del, p2wid, p_bl_off;
  logic [31:0] nut_w, nut_d;
  logic        nut, bl, pu, frame_ok, frame_err, committed, busy;

  int n_chk = 0;
  int n_err = 0;
  int n_ok_seen = 0;
  int n_err_seen = 0;

  logic [154:0] cur;
  logic [154:0] pend;
  bit           pend_vld;

  pulse_param_loader #(.TIMEOUT_CYCLES(TMO), .HEADER(HDR)) dut (
    .clk_pll(clk_pll), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .cycle_start(cycle_start), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
    .nut_w(nut_w), .nut_d(nut_d), .nut(nut), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off),
    .bl(bl), .pu(pu), .frame_ok(frame_ok), .frame_err(frame_err), .committed(committed),
    .busy(busy)
  );

  always #5 clk_pll = ~clk_pll;

  always @(negedge clk_pll) begin
    if (frame_ok)  n_ok_seen++;
    if (frame_err) n_err_seen++;
  end

  function automatic logic [154:0] act_vec();
    return {per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl, nut, pu};
  endfunction

  function automatic logic [154:0] expect_of(input fields_t f);
    return {f.per, f.p1wid, f.del, f.p2wid, f.nut_w, f.nut_d, f.cp, f.p_bl, f.p_bl_off,
            f.flags[2], f.flags[1], f.flags[0]};
  endfunction

  function automatic fields_t mk(input logic [7:0] a, input logic [15:0] b, input logic [15:0] c,
                                 input logic [15:0] d, input logic [31:0] e, input logic [31:0] g,
                                 input logic [7:0] h, input logic [7:0] k, input logic [15:0] m,
                                 input logic [7:0] fl);
    fields_t f;
    f = '{per: a, p1wid: b, del: c, p2wid: d, nut_w: e, nut_d: g, cp: h, p_bl: k,
          p_bl_off: m, flags: fl};
    return f;
  endfunction

  function automatic logic [7:0] byte_of(input fields_t f, input int i);
    logic [159:0] v;
    v = f;
    return v[159-8*i -: 8];
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
`ifndef PARAM_SYNC_COMMIT_EN
    cycle_start = 1'($urandom_range(1, 0));
`endif
    @(negedge clk_pll);
    rx_valid    = 1'b0;
    cycle_start = 1'b0;
    repeat (gap) @(negedge clk_pll);
  endtask

  task automatic pulse_cs();
    bit exp_commit;
    exp_commit = 1'b0;
`ifdef PARAM_SYNC_COMMIT_EN
    if (pend_vld) begin
      cur       = pend;
      pend_vld  = 1'b0;
      exp_commit = 1'b1;
    end
`endif
    cycle_start = 1'b1;
    @(negedge clk_pll);
    cycle_start = 1'b0;
    chk("cs_committed", committed, exp_commit);
    chk("cs_params", act_vec(), cur);
  endtask

  task automatic send_frame(input fields_t f, input logic [7:0] delta, input int maxgap,
                            input bit cs_at_check, output bit got_ok);
    logic [7:0] s;
    bit exp_ok, exp_commit;
    s = 8'd0;
    for (int i = 0; i < 20; i++) s = s + byte_of(f, i);
    exp_ok = (delta == 8'd0);
    send_byte(HDR, $urandom_range(maxgap, 0));
    chk("busy_in_frame", busy, 1'b1);
    for (int i = 0; i < 20; i++) send_byte(byte_of(f, i), $urandom_range(maxgap, 0));
    exp_commit = 1'b0;
`ifdef PARAM_SYNC_COMMIT_EN
    if (cs_at_check && pend_vld) begin
      cur        = pend;
      pend_vld   = 1'b0;
      exp_commit = 1'b1;
    end
    if (exp_ok) begin
      pend     = expect_of(f);
      pend_vld = 1'b1;
    end
`else
    if (exp_ok) begin
      cur        = expect_of(f);
      exp_commit = 1'b1;
    end
`endif
    rx_byte     = s + delta;
    rx_valid    = 1'b1;
    cycle_start = cs_at_check;
    @(negedge clk_pll);
    rx_valid    = 1'b0;
    cycle_start = 1'b0;
    got_ok      = frame_ok;
    chk("frame_ok", frame_ok, exp_ok);
    chk("frame_err", frame_err, !exp_ok);
    chk("committed", committed, exp_commit);
    chk("busy_after", busy, 1'b0);
    chk("params", act_vec(), cur);
    @(negedge clk_pll);
    chk("ok_one_cycle", frame_ok, 1'b0);
    chk("err_one_cycle", frame_err, 1'b0);
  endtask

  vec_t tbl [7];

  initial begin
    bit got;
    int waited, ok0, err0;
    fields_t f;

    tbl[0] = '{mk(8'd2, 16'd40, 16'd200, 16'd40, 32'd100, 32'd300, 8'd5, 8'd50, 16'd100, 8'h07),
               8'd0, 1'b1, 8'd2, 3'b111};
    tbl[1] = '{mk(8'd2, 16'd40, 16'd200, 16'd40, 32'd100, 32'd300, 8'd5, 8'd50, 16'd100, 8'h07),
               8'd1, 1'b0, 8'd2, 3'b111};
    tbl[2] = '{mk(8'hA5, 16'hA5A5, 16'h1234, 16'hA500, 32'hDEADBEEF, 32'h000000A5, 8'hA5, 8'h7E,
                  16'hFFFF, 8'hFA), 8'd0, 1'b1, 8'hA5, 3'b010};
    tbl[3] = '{mk(8'h10, 16'h0001, 16'h0002, 16'h0003, 32'h4, 32'h5, 8'h6, 8'h7, 16'h8, 8'h04),
               8'hFF, 1'b0, 8'hA5, 3'b010};
    tbl[4] = '{mk(8'hFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 8'hFF,
                  16'hFFFF, 8'h01), 8'd0, 1'b1, 8'hFF, 3'b001};
    tbl[5] = '{mk(8'h00, 16'h0, 16'h0, 16'h0, 32'h0, 32'h0, 8'h0, 8'h0, 16'h0, 8'h00),
               8'd0, 1'b1, 8'h00, 3'b000};
    tbl[6] = '{mk(8'h33, 16'h4444, 16'h5555, 16'h6666, 32'h77, 32'h88, 8'h99, 8'hAA, 16'hBB, 8'h05),
               8'h80, 1'b0, 8'h00, 3'b000};

    rx_valid = 1'b0; rx_byte = 8'd0; cycle_start = 1'b0; reset = 1'b1;
    cur = RESET_VEC; pend = RESET_VEC; pend_vld = 1'b0;
    repeat (2) @(negedge clk_pll);
    reset = 1'b0;
    @(negedge clk_pll);
    chk("rst_params", act_vec(), RESET_VEC);
    chk("rst_frame_ok", frame_ok, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_committed", committed, 1'b0);
    chk("rst_busy", busy, 1'b0);

    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].f, tbl[i].delta, 1, 1'b0, got);
`ifdef PARAM_SYNC_COMMIT_EN
      pulse_cs();
`endif
      chk($sformatf("tbl%0d_ok", i), got, tbl[i].exp_ok);
      chk($sformatf("tbl%0d_per", i), per, tbl[i].exp_per);
      chk($sformatf("tbl%0d_flags", i), {bl, nut, pu}, tbl[i].exp_bnp);
    end

    // Non-header bytes while idle are ignored.
    send_byte(8'h00, 0);
    send_byte(8'h5A, 0);
    chk("idle_junk_busy", busy, 1'b0);
    pulse_cs();

    // Inter-byte timeout after header plus five bytes.
    err0 = n_err_seen;
    send_byte(HDR, 0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
    waited = 0;
    got = 1'b0;
    while (!got && waited < int'(TMO) + 20) begin
      if (frame_err) got = 1'b1;
      else begin
        @(negedge clk_pll);
        waited++;
      end
    end
    chk("timeout_fired", got, 1'b1);
    chk("timeout_delay", (waited >= int'(TMO) - 1) && (waited <= int'(TMO) + 1), 1'b1);
    chk("timeout_busy", busy, 1'b0);
    chk("timeout_params", act_vec(), cur);
    @(negedge clk_pll);
    chk("timeout_err_count", n_err_seen - err0, 1);
    f = mk(8'd9, 16'd11, 16'd12, 16'd13, 32'd14, 32'd15, 8'd16, 8'd17, 16'd18, 8'h06);
    send_frame(f, 8'd0, 0, 1'b0, got);
    chk("after_timeout_ok", got, 1'b1);
    pulse_cs();

    // Reset at payload byte 10 discards the frame; the tail bytes are ignored.
    f = mk(8'd1, 16'd2, 16'd3, 16'd4, 32'h11223344, 32'h55667788, 8'd9, 8'd8, 16'h0102, 8'h03);
    send_byte(HDR, 0);
    for (int i = 0; i < 10; i++) send_byte(byte_of(f, i), 0);
    #2 reset = 1'b1;
    #1;
    cur = RESET_VEC;
    pend_vld = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_params", act_vec(), RESET_VEC);
    @(negedge clk_pll);
    reset = 1'b0;
    ok0 = n_ok_seen;
    err0 = n_err_seen;
    for (int i = 10; i < 20; i++) send_byte(byte_of(f, i), 0);
    send_byte(8'h85, 2);
    chk("midrst_tail_busy", busy, 1'b0);
    chk("midrst_tail_pulses", (n_ok_seen - ok0) + (n_err_seen - err0), 0);
    chk("midrst_tail_params", act_vec(), RESET_VEC);
    send_frame(f, 8'd0, 0, 1'b0, got);
    pulse_cs();

`ifdef PARAM_SYNC_COMMIT_EN
    f = mk(8'd4, 16'd1, 16'd1, 16'd1, 32'd1, 32'd1, 8'd1, 8'd1, 16'd1, 8'h00);
    send_frame(f, 8'd0, 0, 1'b0, got);
    chk("sync_hold_per", per, 8'd1);
    pulse_cs();
    chk("sync_commit_per", per, 8'd4);
    pulse_cs();
    f.per = 8'd7;
    send_frame(f, 8'd0, 0, 1'b0, got);
    f.per = 8'd9;
    send_frame(f, 8'd0, 0, 1'b0, got);
    pulse_cs();
    chk("sync_newest_per", per, 8'd9);
    f.per = 8'h21;
    send_frame(f, 8'd0, 0, 1'b0, got);
    f.per = 8'h22;
    send_frame(f, 8'd0, 0, 1'b1, got);
    chk("sync_same_cycle_per", per, 8'h21);
    pulse_cs();
    chk("sync_second_per", per, 8'h22);
`endif

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(3, 0) == 0) send_byte(8'h3C, $urandom_range(2, 0));
      f = fields_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      send_frame(f, ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0, 3,
                 1'($urandom_range(1, 0)), got);
      if ($urandom_range(1, 0) == 1) pulse_cs();
    end
    pulse_cs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
